encoder_controller: RTL and testbench
=====================================

Name: encoder_controller

Overview:
- Control FSM that sequences the Keccak-style encoder datapath.
- For each input file it runs NUM_ROUNDS rounds; each round runs five stages in fixed order: column parity (CP), rotate (RO), permute (PE), revaluate (RE), add round constant (RC).
- Sits directly upstream of encoder_datapath: drives file_index, iteration and the five *_start strobes, and consumes the five *_finish signals.

Parameters:
- NUM_FILES, 64, number of files processed per run (1..1024; file_index is 10 bits).
- NUM_ROUNDS, 24, rounds per file (1..32; iteration is 5 bits).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  run request; sampled only in IDLE.
- CP_finish, RO_finish, PE_finish, RE_finish, RC_finish  input  1 each  stage-complete indications from the datapath.
- CP_start, RO_start, PE_start, RE_start, RC_start  output  1 each  one-cycle stage start strobes.
- file_index  output  10  current file number.
- iteration  output  5  current round number.
- busy  output  1  high from the cycle after go is accepted until the DONE cycle, inclusive.
- done  output  1  one-cycle pulse when the whole run completes.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; file_index=0; iteration=0. Reset mid-run aborts at once to these values. In-flight datapath finishes after that are ignored.
- States: IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT, RE_GO, RE_WAIT, RC_GO, RC_WAIT, DONE.
- Outputs are Moore, decoded from the registered state. X_start=1 exactly in state X_GO, so each strobe lasts one cycle per stage.
- IDLE: go=1 -> CP_GO; otherwise stay. go in any other state is ignored.
- X_GO -> X_WAIT unconditionally. A finish input is never sampled during a GO cycle.
- X_WAIT: stay until X_finish=1, then move to the next stage's GO (CP->RO->PE->RE->RC).
  - Only the matching finish is honoured. Finishes from other stages are ignored in every state.
  - Finish in IDLE or DONE is ignored.
- RC_WAIT with RC_finish=1:
  - iteration < NUM_ROUNDS-1: iteration++ -> CP_GO.
  - iteration == NUM_ROUNDS-1 and file_index < NUM_FILES-1: iteration<=0, file_index++ -> CP_GO.
  - iteration == NUM_ROUNDS-1 and file_index == NUM_FILES-1: -> DONE.
- DONE: done=1, busy=1 for one cycle; file_index<=0 and iteration<=0; -> IDLE.
- file_index and iteration change only on the RC_WAIT->CP_GO/DONE transition. They are stable through all five stages of a round.
- Latency:
  - go sampled at edge k -> CP_start high in cycle k+1.
  - finish sampled at edge m -> next stage's start high in cycle m+1.
  - Minimum round length 10 cycles (every finish returned in the first WAIT cycle).
- Total strobes per run: NUM_FILES*NUM_ROUNDS for each of the five starts.
- Counter arithmetic is unsigned and never wraps. Terminal compares use NUM_*-1, so NUM_ROUNDS=1 or NUM_FILES=1 are legal.

Test Plan:
- Reset then go=1 for one cycle, with a datapath model returning each finish 3 cycles after start -> CP_start in the cycle after go. Order is CP,RO,PE,RE,RC. Each start is exactly 1 cycle wide. iteration=0 and file_index=0 throughout round 0.
- Defaults (64 files, 24 rounds), finish returned 1 cycle after start -> exactly 1536 pulses on each start. Last round has file_index=63, iteration=23. done pulses once. busy falls with done. Outputs return to 0.
- NUM_FILES=2, NUM_ROUNDS=2 -> sequence (file,iter) = (0,0),(0,1),(1,0),(1,1). Each round is 10 cycles with immediate finishes. done occurs 41 cycles after go.
- In CP_WAIT, pulse RO_finish, RC_finish and a second go -> state, counters and strobes unchanged. Then CP_finish -> RO_start next cycle.
- Assert rst during RE_WAIT of file 5, iteration 7 -> next cycle all outputs 0, state IDLE. A late RE_finish is ignored. A new go restarts at file 0, iteration 0.
- Hold CP_finish=1 continuously from reset, then go -> CP_GO lasts exactly 1 cycle. CP_WAIT exits after 1 cycle. No double strobe occurs.

Source files
------------

// File: rtl/encoder_controller.sv
// Control FSM for the Keccak-style encoder datapath: walks every file through
// NUM_ROUNDS rounds of CP, RO, PE, RE, RC and hands out one-cycle start strobes.
module encoder_controller #(
  parameter int NUM_FILES  = 64,
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       CP_finish,
  input  logic       RO_finish,
  input  logic       PE_finish,
  input  logic       RE_finish,
  input  logic       RC_finish,
  output logic       CP_start,
  output logic       RO_start,
  output logic       PE_start,
  output logic       RE_start,
  output logic       RC_start,
  output logic [9:0] file_index,
  output logic [4:0] iteration,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT,
    RE_GO, RE_WAIT, RC_GO, RC_WAIT, DONE
  } state_e;

  localparam logic [9:0] LastFile  = 10'(NUM_FILES - 1);
  localparam logic [4:0] LastRound = 5'(NUM_ROUNDS - 1);

  state_e     state_q, state_d;
  logic [9:0] file_q, file_d;
  logic [4:0] iter_q, iter_d;

  // Only the finish belonging to the stage being waited on can advance the FSM.
  always_comb begin
    state_d = state_q;
    file_d  = file_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:    if (go) state_d = CP_GO;
      CP_GO:   state_d = CP_WAIT;
      CP_WAIT: if (CP_finish) state_d = RO_GO;
      RO_GO:   state_d = RO_WAIT;
      RO_WAIT: if (RO_finish) state_d = PE_GO;
      PE_GO:   state_d = PE_WAIT;
      PE_WAIT: if (PE_finish) state_d = RE_GO;
      RE_GO:   state_d = RE_WAIT;
      RE_WAIT: if (RE_finish) state_d = RC_GO;
      RC_GO:   state_d = RC_WAIT;
      RC_WAIT: begin
        if (RC_finish) begin
          if (iter_q < LastRound) begin
            iter_d  = iter_q + 5'd1;
            state_d = CP_GO;
          end else if (file_q < LastFile) begin
            iter_d  = '0;
            file_d  = file_q + 10'd1;
            state_d = CP_GO;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        file_d  = '0;
        iter_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are a clean Moore decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      file_q   <= '0;
      iter_q   <= '0;
      CP_start <= 1'b0;
      RO_start <= 1'b0;
      PE_start <= 1'b0;
      RE_start <= 1'b0;
      RC_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      file_q   <= file_d;
      iter_q   <= iter_d;
      CP_start <= (state_d == CP_GO);
      RO_start <= (state_d == RO_GO);
      PE_start <= (state_d == PE_GO);
      RE_start <= (state_d == RE_GO);
      RC_start <= (state_d == RC_GO);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

  assign file_index = file_q;
  assign iteration  = iter_q;

endmodule

// File: tb/tb_encoder_controller.sv
// Randomized bench for encoder_controller: a responder returns finishes after
// random delays while a file/round/stage walk predicts every output cycle.
module tb_encoder_controller;

  localparam int NF = 64;
  localparam int NR = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [4:0] fin = '0;
  logic       cpS, roS, peS, reS, rcS;
  logic [9:0] fileIndex;
  logic [4:0] iteration;
  logic       busy, done;
  logic [4:0] starts;

  int vectorCount = 0;
  int missCount = 0;
  int startCount[5];
  int doneCount = 0;

  always #5 clk = ~clk;

  encoder_controller #(.NUM_FILES(NF), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .go(go),
    .CP_finish(fin[0]), .RO_finish(fin[1]), .PE_finish(fin[2]),
    .RE_finish(fin[3]), .RC_finish(fin[4]),
    .CP_start(cpS), .RO_start(roS), .PE_start(peS), .RE_start(reS), .RC_start(rcS),
    .file_index(fileIndex), .iteration(iteration), .busy(busy), .done(done)
  );

  assign starts = {rcS, reS, peS, roS, cpS};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic goV, input logic [4:0] finV, input logic rstV);
    go  = goV;
    fin = finV;
    rst = rstV;
  endtask

  // Advance to the next falling edge and tally the strobes seen in that cycle.
  task automatic tick();
    @(negedge clk);
    for (int s = 0; s < 5; s++) if (starts[s]) startCount[s]++;
    if (done) doneCount++;
  endtask

  task automatic expectCycle(input string tag, input logic [4:0] st, input int f, input int it,
                             input logic b, input logic d);
    checkOutput({tag, "_start"}, 32'(starts), 32'(st));
    checkOutput({tag, "_file"}, 32'(fileIndex), 32'(f));
    checkOutput({tag, "_iter"}, 32'(iteration), 32'(it));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(b));
    checkOutput({tag, "_done"}, 32'(done), 32'(d));
  endtask

  // One complete run from IDLE; abortRound >= 0 resets during that round's RE wait.
  task automatic runRun(input int maxLat, input int abortRound);
    int         lat;
    logic [4:0] noise;
    for (int s = 0; s < 5; s++) startCount[s] = 0;
    doneCount = 0;
    applyStimulus(1'b1, 5'($urandom), 1'b0);
    tick();
    for (int f = 0; f < NF; f++) begin
      for (int r = 0; r < NR; r++) begin
        for (int s = 0; s < 5; s++) begin
          expectCycle("go", 5'(1 << s), f, r, 1'b1, 1'b0);
          applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
          tick();
          lat = $urandom_range(1, maxLat);
          for (int w = 1; w <= lat; w++) begin
            expectCycle("wait", 5'b0, f, r, 1'b1, 1'b0);
            if (f * NR + r == abortRound && s == 3) begin
              applyStimulus(1'b0, 5'b0, 1'b1);
              tick();
              expectCycle("rst", 5'b0, 0, 0, 1'b0, 1'b0);
              applyStimulus(1'b0, 5'b01000, 1'b0);
              tick();
              expectCycle("post_rst", 5'b0, 0, 0, 1'b0, 1'b0);
              applyStimulus(1'b0, 5'b0, 1'b0);
              return;
            end
            noise = 5'($urandom) & ~5'(1 << s);
            if (w == lat) noise = noise | 5'(1 << s);
            applyStimulus(1'($urandom_range(0, 1)), noise, 1'b0);
            tick();
          end
        end
      end
    end
    checkOutput("done_start", 32'(starts), 32'h0);
    checkOutput("done_busy", 32'(busy), 32'h1);
    checkOutput("done_pulse", 32'(done), 32'h1);
    applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
    tick();
    expectCycle("idle", 5'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h1f, 1'b0);
    tick();
    expectCycle("idle_hold", 5'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b0, 1'b0);
    for (int s = 0; s < 5; s++) checkOutput("start_total", 32'(startCount[s]), 32'(NF * NR));
    checkOutput("done_total", 32'(doneCount), 32'h1);
  endtask

  initial begin
    applyStimulus(1'b0, 5'b0, 1'b1);
    tick();
    tick();
    expectCycle("reset", 5'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b0, 1'b0);
    tick();

    $display("[TB] full run, immediate finishes");
    runRun(1, -1);
    $display("[TB] random latency run aborted at file 5 round 7");
    runRun(3, 5 * NR + 7);
    $display("[TB] random latency full run after abort");
    runRun(3, -1);

    // CP_finish held high from reset must not skip or double the CP stage.
    applyStimulus(1'b0, 5'b00001, 1'b1);
    tick();
    expectCycle("hold_reset", 5'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00001, 1'b0);
    tick();
    expectCycle("hold_cp_go", 5'b00001, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00001, 1'b0);
    tick();
    expectCycle("hold_cp_wait", 5'b0, 0, 0, 1'b1, 1'b0);
    tick();
    expectCycle("hold_ro_go", 5'b00010, 0, 0, 1'b1, 1'b0);
    tick();
    expectCycle("hold_ro_wait", 5'b0, 0, 0, 1'b1, 1'b0);
    tick();
    expectCycle("hold_ro_wait2", 5'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b0, 1'b1);
    tick();
    expectCycle("final_reset", 5'b0, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
